cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences a CPU through reset, a budgeted run and a data-memory
// dump walk, gating the CPU clock enable and data-memory writes along the way.
module cpu_run_ctrl #(
    parameter int unsigned MAX_CYCLES = 250000,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned DUMP_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_finished,
    input  logic [31:0] pc,
    input  logic        cpu_memwrite,
    input  logic        dump_ready,
    output logic        cpu_reset,
    output logic        cpu_en,
    output logic        mem_we,
    output logic [31:0] cycle_count,
    output logic        dump_valid,
    output logic [31:0] dump_addr,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int unsigned DW    = 32;
    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [DW-1:0]    CNT_LAST  = DW'(MAX_CYCLES - 1);
    localparam logic [DW-1:0]    ADDR_LAST = DW'(4 * (DUMP_WORDS - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [RST_W-1:0] r_rst_cnt;
    logic             r_cpu_reset;
    logic [DW-1:0]    r_cycle_count;
    logic             r_dump_valid;
    logic [DW-1:0]    r_dump_addr;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic             w_halt;
    logic             w_cpu_en;
    logic [DW-1:0]    w_cnt_inc;

    // Halt detection and the combinational enable that keeps the halt-PC cycle from executing
    assign w_halt    = (pc == pc_finished);
    assign w_cpu_en  = (r_state == S_RUN) && !w_halt;
    assign w_cnt_inc = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + DW'(1);

    assign cpu_en      = w_cpu_en;
    assign mem_we      = cpu_memwrite && w_cpu_en;
    assign cpu_reset   = r_cpu_reset;
    assign cycle_count = r_cycle_count;
    assign dump_valid  = r_dump_valid;
    assign dump_addr   = r_dump_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;

    // Run-control FSM; registered outputs are updated together with each transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_cpu_reset   <= 1'b1;
            r_cycle_count <= '0;
            r_dump_valid  <= 1'b0;
            r_dump_addr   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_RST;
                        r_rst_cnt     <= '0;
                        r_cycle_count <= '0;
                        r_dump_addr   <= '0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end
                end
                S_RUN: begin
                    // Halt wins: at the halt PC the enable is low, so the budget check cannot fire
                    if (w_halt) begin
                        r_state      <= S_DUMP;
                        r_dump_valid <= 1'b1;
                        r_dump_addr  <= '0;
                    end else begin
                        r_cycle_count <= w_cnt_inc;
                        if (r_cycle_count == CNT_LAST) begin
                            r_state     <= S_DONE;
                            r_timeout   <= 1'b1;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (r_dump_addr == ADDR_LAST) begin
                            r_state      <= S_DONE;
                            r_dump_addr  <= '0;
                            r_dump_valid <= 1'b0;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_cpu_reset  <= 1'b1;
                        end else begin
                            r_dump_addr <= r_dump_addr + DW'(4);
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cpu_reset  <= 1'b1;
                    r_dump_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed and randomized checks of cpu_run_ctrl against a
// cycle-level behavioural model, with a stub CPU that steps PC by 4.
module tb_cpu_run_ctrl;

    localparam int unsigned MAXC = 16;
    localparam int unsigned RSTC = 2;
    localparam int unsigned DWRD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_finished = 32'h0;
    logic [31:0] pc;
    logic        cpu_memwrite = 1'b0;
    logic        dump_ready = 1'b0;
    logic        cpu_reset, cpu_en, mem_we, dump_valid, busy, done, timeout;
    logic [31:0] cycle_count, dump_addr;

    int n_total = 0;
    int n_bad   = 0;

    cpu_run_ctrl #(
        .MAX_CYCLES(MAXC),
        .RST_CYCLES(RSTC),
        .DUMP_WORDS(DWRD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc_finished(pc_finished),
        .pc(pc), .cpu_memwrite(cpu_memwrite), .dump_ready(dump_ready),
        .cpu_reset(cpu_reset), .cpu_en(cpu_en), .mem_we(mem_we),
        .cycle_count(cycle_count), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Stub CPU: PC held at 0 in reset, advances by 4 on each enabled cycle
    always @(posedge clk or negedge reset) begin
        if (!reset)         pc <= 32'h0;
        else if (cpu_reset) pc <= 32'h0;
        else if (cpu_en)    pc <= pc + 32'd4;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        n_total++;
        n_bad++;
        $display("FAIL %s actual=no-event required=event-within-budget at %0t", nm, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_RST, P_RUN, P_DUMP, P_DONE} phase_t;
    phase_t      m_phase = P_IDLE;
    int unsigned m_rst_edges = 0;
    longint unsigned m_cnt = 0;
    int unsigned m_addr = 0;
    bit          m_done = 0;
    bit          m_to = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = P_IDLE; m_cnt = 0; m_addr = 0; m_done = 0; m_to = 0; m_rst_edges = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (start) begin
                    m_phase = P_RST; m_rst_edges = 0;
                    m_cnt = 0; m_addr = 0; m_done = 0; m_to = 0;
                end
                P_RST: begin
                    m_rst_edges++;
                    if (m_rst_edges == RSTC) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (pc == pc_finished) begin
                        m_phase = P_DUMP; m_addr = 0;
                    end else begin
                        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
                        if (m_cnt == MAXC) begin
                            m_phase = P_DONE; m_to = 1; m_done = 1;
                        end
                    end
                end
                P_DUMP: if (dump_ready) begin
                    if (m_addr == 4 * (DWRD - 1)) begin
                        m_phase = P_DONE; m_done = 1; m_addr = 0;
                    end else begin
                        m_addr = m_addr + 4;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        bit e_en;
        e_en = (m_phase == P_RUN) && (pc != pc_finished);
        chk("cpu_reset",   32'(cpu_reset),   32'(m_phase == P_IDLE || m_phase == P_RST || m_phase == P_DONE));
        chk("cpu_en",      32'(cpu_en),      32'(e_en));
        chk("mem_we",      32'(mem_we),      32'(cpu_memwrite && e_en));
        chk("cycle_count", cycle_count,      32'(m_cnt));
        chk("dump_valid",  32'(dump_valid),  32'(m_phase == P_DUMP));
        chk("dump_addr",   dump_addr,        m_addr);
        chk("busy",        32'(busy),        32'(m_phase == P_RST || m_phase == P_RUN || m_phase == P_DUMP));
        chk("done",        32'(done),        32'(m_done));
        chk("timeout",     32'(timeout),     32'(m_to));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until done, tallying reset-held cycles, enabled cycles and whether a dump occurred
    task automatic run_to_done(input string nm, output int rst_c, output int en_c, output bit dv);
        bit got;
        rst_c = 0; en_c = 0; dv = 0; got = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy && cpu_reset) rst_c++;
            if (cpu_en) en_c++;
            if (dump_valid) dv = 1;
            if (done) begin got = 1; break; end
            tick();
        end
        if (!got) expire(nm);
    endtask

    int rc, ec;
    bit dv;
    logic [31:0] seq [$];
    logic [31:0] exp_seq [7];

    initial begin
        exp_seq = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC};
        cpu_memwrite = 1'b1;
        repeat (3) tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_cycles",    cycle_count,    32'h0);
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_no_start_busy", 32'(busy), 32'h0);

        // Basic run; halt lands on the same edge as the final budget cycle
        pc_finished = 32'h3C;
        dump_ready  = 1'b1;
        pulse_start();
        run_to_done("basic_done", rc, ec, dv);
        chk("basic_rst_cycles", 32'(rc), 32'd2);
        chk("basic_en_cycles",  32'(ec), 32'd15);
        chk("basic_count",      cycle_count, 32'd15);
        chk("basic_timeout",    32'(timeout), 32'h0);
        chk("basic_dumped",     32'(dv), 32'h1);
        repeat (2) tick();

        // Budget exhaustion
        pc_finished = 32'hFFFF_FFF0;
        pulse_start();
        run_to_done("timeout_done", rc, ec, dv);
        chk("to_en_cycles", 32'(ec), 32'd16);
        chk("to_count",     cycle_count, 32'd16);
        chk("to_timeout",   32'(timeout), 32'h1);
        chk("to_done",      32'(done), 32'h1);
        chk("to_no_dump",   32'(dv), 32'h0);
        repeat (2) tick();

        // Dump backpressure with ready alternating 1,0,1,0...
        pc_finished = 32'h8;
        dump_ready  = 1'b0;
        pulse_start();
        for (int i = 0; i < 100 && !dump_valid; i++) tick();
        if (!dump_valid) expire("bp_dump_entry");
        dump_ready = 1'b1;
        seq.delete();
        for (int i = 0; i < 20; i++) begin
            if (!dump_valid) break;
            seq.push_back(dump_addr);
            tick();
            dump_ready = ~dump_ready;
        end
        dump_ready = 1'b0;
        chk("bp_beats", 32'(seq.size()), 32'd7);
        for (int i = 0; i < 7 && i < seq.size(); i++) chk("bp_addr_seq", seq[i], exp_seq[i]);
        chk("bp_done", 32'(done), 32'h1);
        chk("bp_timeout", 32'(timeout), 32'h0);
        repeat (2) tick();

        // Reset asserted mid-dump at address 8
        dump_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 100 && !(dump_valid && dump_addr == 32'h8); i++) tick();
        if (!(dump_valid && dump_addr == 32'h8)) expire("mid_dump_reach");
        reset = 1'b0;
        #1;
        chk("mr_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("mr_cpu_en",    32'(cpu_en),    32'h0);
        chk("mr_mem_we",    32'(mem_we),    32'h0);
        chk("mr_count",     cycle_count,    32'h0);
        chk("mr_valid",     32'(dump_valid), 32'h0);
        chk("mr_addr",      dump_addr,      32'h0);
        chk("mr_busy",      32'(busy),      32'h0);
        chk("mr_done",      32'(done),      32'h0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("mr_stay_idle", 32'(busy), 32'h0);
        pulse_start();
        chk("mr_restart_busy",  32'(busy), 32'h1);
        chk("mr_restart_creset", 32'(cpu_reset), 32'h1);
        chk("mr_restart_count", cycle_count, 32'h0);
        run_to_done("mr_restart_done", rc, ec, dv);
        chk("mr_restart_rst_cycles", 32'(rc), 32'd2);

        // Randomized traffic, including starts while busy and occasional resets
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 7) == 0);
            dump_ready   = $urandom_range(0, 1) == 1;
            cpu_memwrite = $urandom_range(0, 1) == 1;
            if ((m_phase == P_IDLE || m_phase == P_DONE) && $urandom_range(0, 3) == 0)
                pc_finished = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0
                                                          : 32'(4 * $urandom_range(0, 20));
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
